// File: rtl/alu_bist_pkg.sv
// rtl/alu_bist_pkg.sv - shared types and constants for the ALU self-test controller
package alu_bist_pkg;

  // Controller states
  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_LOAD    = 3'd1,
    ST_DRIVE   = 3'd2,
    ST_CAPTURE = 3'd3,
    ST_DONE    = 3'd4
  } bist_state_t;

  // Galois LFSR taps used to generate operand pairs
  localparam logic [31:0] LFSR_TAPS = 32'h8020_0003;

  // MISR feedback polynomial and the value loaded at the start of a run
  localparam logic [31:0] MISR_POLY = 32'h04C1_1DB7;
  localparam logic [31:0] MISR_INIT = 32'hFFFF_FFFF;

  // Fixed corner-case operands applied in round 1
  localparam logic [31:0] ROUND1_A = 32'h8000_0000;
  localparam logic [31:0] ROUND1_B = 32'h0000_0001;

  // Processor ALU operation codes; ALU_A (pass-through) marks the end of the swept set
  localparam logic [3:0] ALU_ADD  = 4'd0;
  localparam logic [3:0] ALU_SUB  = 4'd1;
  localparam logic [3:0] ALU_AND  = 4'd2;
  localparam logic [3:0] ALU_OR   = 4'd3;
  localparam logic [3:0] ALU_XOR  = 4'd4;
  localparam logic [3:0] ALU_SLL  = 4'd5;
  localparam logic [3:0] ALU_SRL  = 4'd6;
  localparam logic [3:0] ALU_SRA  = 4'd7;
  localparam logic [3:0] ALU_SLT  = 4'd8;
  localparam logic [3:0] ALU_SLTU = 4'd9;
  localparam logic [3:0] ALU_A    = 4'd10;

  // One Galois LFSR shift
  function automatic logic [31:0] lfsr_step(input logic [31:0] l);
    return (l >> 1) ^ (l[0] ? LFSR_TAPS : 32'h0);
  endfunction

endpackage

// File: rtl/alu_bist_misr.sv
// rtl/alu_bist_misr.sv - 32-bit multiple-input signature register
module alu_bist_misr
  import alu_bist_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        init_i,
  input  logic        en_i,
  input  logic [31:0] data_i,
  output logic [31:0] sig_o,
  output logic [31:0] sig_next_o
);

  logic [31:0] sig_q;

  // Next value is exposed so the controller can judge pass on the final capture
  assign sig_next_o = ((sig_q << 1) ^ (sig_q[31] ? MISR_POLY : 32'h0)) ^ data_i;
  assign sig_o      = sig_q;

  // Signature register: init wins over a compaction step
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sig_q <= 32'h0;
    end else if (init_i) begin
      sig_q <= MISR_INIT;
    end else if (en_i) begin
      sig_q <= sig_next_o;
    end
  end

endmodule

// File: rtl/alu_bist.sv
// rtl/alu_bist.sv - ALU self-test controller: operand sweep, MISR compaction, golden compare
module alu_bist_ctrl
  import alu_bist_pkg::*;
#(
  parameter int unsigned N_ROUNDS     = 16,
  parameter int unsigned N_OPS        = 32'(ALU_A),
  parameter int unsigned SETTLE       = 1,
  parameter logic [31:0] LFSR_SEED    = 32'hACE1_1234,
  parameter logic [31:0] SIG_EXPECTED = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        start,
  input  logic        abort,
  output logic        bist_en,
  output logic [3:0]  alu_sel,
  output logic [31:0] bus_a,
  output logic [31:0] bus_b,
  input  logic [31:0] alu_out,
  input  logic        alu_zero,
  input  logic        alu_neg,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic [31:0] signature
);

  localparam int unsigned RW = (N_ROUNDS > 1) ? $clog2(N_ROUNDS) : 1;
  localparam int unsigned SW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [RW-1:0] LAST_ROUND  = RW'(N_ROUNDS - 1);
  localparam logic [3:0]    LAST_OP     = 4'(N_OPS - 1);
  localparam logic [SW-1:0] LAST_SETTLE = SW'(SETTLE - 1);
  // A zero seed would lock the LFSR at zero
  localparam logic [31:0]   SEED        = (LFSR_SEED == 32'h0) ? 32'h1 : LFSR_SEED;

  bist_state_t   state_q, state_d;
  logic [RW-1:0] round_q, round_d;
  logic [SW-1:0] settle_q, settle_d;
  logic [3:0]    sel_q, sel_d;
  logic [31:0]   a_q, a_d;
  logic [31:0]   b_q, b_d;
  logic [31:0]   lfsr_q, lfsr_d;
  logic          bist_en_q, bist_en_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          pass_q, pass_d;

  logic          misr_init;
  logic          misr_en;
  logic [31:0]   misr_data;
  logic [31:0]   misr_sig;
  logic [31:0]   misr_next;
  logic [31:0]   lfsr_s1;
  logic [31:0]   lfsr_s2;
  logic          run_state;
  logic          start_ok;
  logic          last_op;
  logic          last_round;
  logic          last_settle;

  assign run_state   = (state_q == ST_LOAD) || (state_q == ST_DRIVE) || (state_q == ST_CAPTURE);
  // Abort suppresses a simultaneous start
  assign start_ok    = start && !abort;
  assign last_op     = (sel_q == LAST_OP);
  assign last_round  = (round_q == LAST_ROUND);
  assign last_settle = (settle_q == LAST_SETTLE);

  // Two LFSR steps per generated round: first feeds A, second feeds B
  assign lfsr_s1 = lfsr_step(lfsr_q);
  assign lfsr_s2 = lfsr_step(lfsr_s1);

  // Flags are folded into the low bits of the compacted word
  assign misr_data = alu_out ^ {30'b0, alu_neg, alu_zero};

  alu_bist_misr u_misr (
    .clk        (clk),
    .rst_n      (rstn),
    .init_i     (misr_init),
    .en_i       (misr_en),
    .data_i     (misr_data),
    .sig_o      (misr_sig),
    .sig_next_o (misr_next)
  );

  // State register
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE, ST_DONE: if (start_ok) state_d = ST_LOAD;
      ST_LOAD:          state_d = ST_DRIVE;
      ST_DRIVE:         if (last_settle) state_d = ST_CAPTURE;
      ST_CAPTURE: begin
        if (!last_op)         state_d = ST_DRIVE;
        else if (!last_round) state_d = ST_LOAD;
        else                  state_d = ST_DONE;
      end
      default:          state_d = ST_IDLE;
    endcase
    if (abort && run_state) state_d = ST_IDLE;
  end

  // Output and datapath next values
  always_comb begin
    round_d   = round_q;
    settle_d  = settle_q;
    sel_d     = sel_q;
    a_d       = a_q;
    b_d       = b_q;
    lfsr_d    = lfsr_q;
    bist_en_d = bist_en_q;
    busy_d    = busy_q;
    done_d    = done_q;
    pass_d    = pass_q;
    misr_init = 1'b0;
    misr_en   = 1'b0;
    unique case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start_ok) begin
          round_d   = '0;
          settle_d  = '0;
          lfsr_d    = SEED;
          bist_en_d = 1'b1;
          busy_d    = 1'b1;
          done_d    = 1'b0;
          pass_d    = 1'b0;
          misr_init = 1'b1;
        end
      end
      ST_LOAD: begin
        sel_d    = 4'd0;
        settle_d = '0;
        if (round_q == RW'(0)) begin
          a_d = 32'h0;
          b_d = 32'h0;
        end else if (round_q == RW'(1)) begin
          a_d = ROUND1_A;
          b_d = ROUND1_B;
        end else begin
          a_d    = lfsr_s1;
          // Odd generated rounds exercise small shift amounts
          b_d    = round_q[0] ? {27'b0, lfsr_s2[4:0]} : lfsr_s2;
          lfsr_d = lfsr_s2;
        end
      end
      ST_DRIVE: begin
        if (!last_settle) settle_d = settle_q + SW'(1);
      end
      ST_CAPTURE: begin
        misr_en  = 1'b1;
        settle_d = '0;
        if (!last_op) begin
          sel_d = sel_q + 4'd1;
        end else if (!last_round) begin
          round_d = round_q + RW'(1);
        end else begin
          bist_en_d = 1'b0;
          busy_d    = 1'b0;
          done_d    = 1'b1;
          pass_d    = (misr_next == SIG_EXPECTED);
        end
      end
      default: begin
        bist_en_d = 1'b0;
        busy_d    = 1'b0;
      end
    endcase
    // Abort releases the ALU and drops any result; the signature is left as is
    if (abort && run_state) begin
      bist_en_d = 1'b0;
      busy_d    = 1'b0;
      done_d    = 1'b0;
      pass_d    = 1'b0;
      misr_en   = 1'b0;
    end
  end

  // Registered outputs and counters
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      round_q   <= '0;
      settle_q  <= '0;
      sel_q     <= 4'd0;
      a_q       <= 32'h0;
      b_q       <= 32'h0;
      lfsr_q    <= SEED;
      bist_en_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      pass_q    <= 1'b0;
    end else begin
      round_q   <= round_d;
      settle_q  <= settle_d;
      sel_q     <= sel_d;
      a_q       <= a_d;
      b_q       <= b_d;
      lfsr_q    <= lfsr_d;
      bist_en_q <= bist_en_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      pass_q    <= pass_d;
    end
  end

  assign bist_en   = bist_en_q;
  assign alu_sel   = sel_q;
  assign bus_a     = a_q;
  assign bus_b     = b_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign pass      = pass_q;
  assign signature = misr_sig;

endmodule

// File: tb/tb_alu_bist_ctrl.sv
// tb/tb_alu_bist_ctrl.sv - self-checking bench for alu_bist_ctrl against a behavioural ALU/MISR model
module tb_alu_bist_ctrl;
  import alu_bist_pkg::*;

  localparam int NOPS       = 32'(ALU_A);
  localparam int BIG_ROUNDS = 16;
  localparam int ROUND_LEN  = 1 + NOPS * 2;
  localparam int BIG_LAT    = BIG_ROUNDS * ROUND_LEN + 1;
  localparam int SMALL_LAT  = 2 * ROUND_LEN + 1;

  // Reference ALU
  function automatic logic [31:0] alu_fn(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] r;
    case (op)
      ALU_ADD:  r = a + b;
      ALU_SUB:  r = a - b;
      ALU_AND:  r = a & b;
      ALU_OR:   r = a | b;
      ALU_XOR:  r = a ^ b;
      ALU_SLL:  r = a << b[4:0];
      ALU_SRL:  r = a >> b[4:0];
      ALU_SRA:  r = $unsigned($signed(a) >>> b[4:0]);
      ALU_SLT:  r = {31'b0, $signed(a) < $signed(b)};
      ALU_SLTU: r = {31'b0, a < b};
      default:  r = a;
    endcase
    return r;
  endfunction

  // Expected signature of a whole run, computed round by round from the operand rules
  function automatic logic [31:0] model_signature(input int rounds, input bit fault);
    logic [31:0] sig, l, a, b, r, o;
    sig = 32'hFFFF_FFFF;
    l   = 32'hACE1_1234;
    a   = 32'h0;
    b   = 32'h0;
    for (int rd = 0; rd < rounds; rd++) begin
      if (rd == 0) begin
        a = 32'h0;
        b = 32'h0;
      end else if (rd == 1) begin
        a = 32'h8000_0000;
        b = 32'h1;
      end else begin
        l = (l >> 1) ^ (l[0] ? 32'h8020_0003 : 32'h0);
        a = l;
        l = (l >> 1) ^ (l[0] ? 32'h8020_0003 : 32'h0);
        b = (rd % 2 == 1) ? (l & 32'h1F) : l;
      end
      for (int op = 0; op < NOPS; op++) begin
        r   = alu_fn(4'(op), a, b);
        o   = (fault && 4'(op) == ALU_AND) ? (r | 32'h1) : r;
        sig = ((sig << 1) ^ (sig[31] ? 32'h04C1_1DB7 : 32'h0)) ^ o ^ {30'b0, r[31], r == 32'h0};
      end
    end
    return sig;
  endfunction

  localparam logic [31:0] SIG_GOLD = model_signature(BIG_ROUNDS, 1'b0);

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rstn;
  bit          fault_and;
  int          checks;
  int          failures;

  // Full-size DUT with the model signature as golden value
  logic        b_start, b_abort, b_bist_en, b_busy, b_done, b_pass, b_zero, b_neg;
  logic [3:0]  b_sel;
  logic [31:0] b_a, b_b, b_out, b_res, b_sig;

  assign b_res  = alu_fn(b_sel, b_a, b_b);
  assign b_out  = (fault_and && b_sel == ALU_AND) ? (b_res | 32'h1) : b_res;
  assign b_zero = (b_res == 32'h0);
  assign b_neg  = b_res[31];

  alu_bist_ctrl #(
    .N_ROUNDS     (BIG_ROUNDS),
    .N_OPS        (NOPS),
    .SETTLE       (1),
    .LFSR_SEED    (32'hACE1_1234),
    .SIG_EXPECTED (SIG_GOLD)
  ) u_dut (
    .clk       (clk),
    .rstn      (rstn),
    .start     (b_start),
    .abort     (b_abort),
    .bist_en   (b_bist_en),
    .alu_sel   (b_sel),
    .bus_a     (b_a),
    .bus_b     (b_b),
    .alu_out   (b_out),
    .alu_zero  (b_zero),
    .alu_neg   (b_neg),
    .busy      (b_busy),
    .done      (b_done),
    .pass      (b_pass),
    .signature (b_sig)
  );

  // Two-round DUT for sequence and latency checks
  logic        s_start, s_abort, s_bist_en, s_busy, s_done, s_pass, s_zero, s_neg;
  logic [3:0]  s_sel;
  logic [31:0] s_a, s_b, s_res, s_sig;

  assign s_res  = alu_fn(s_sel, s_a, s_b);
  assign s_zero = (s_res == 32'h0);
  assign s_neg  = s_res[31];

  alu_bist_ctrl #(
    .N_ROUNDS (2),
    .SETTLE   (1)
  ) u_small (
    .clk       (clk),
    .rstn      (rstn),
    .start     (s_start),
    .abort     (s_abort),
    .bist_en   (s_bist_en),
    .alu_sel   (s_sel),
    .bus_a     (s_a),
    .bus_b     (s_b),
    .alu_out   (s_res),
    .alu_zero  (s_zero),
    .alu_neg   (s_neg),
    .busy      (s_busy),
    .done      (s_done),
    .pass      (s_pass),
    .signature (s_sig)
  );

  // Start the big DUT, optionally re-pulse start at edge mid_k; returns edge index of first done or -1
  task automatic big_run(input int mid_k, output int done_k);
    done_k  = -1;
    b_start = 1'b1;
    for (int k = 0; k < BIG_LAT + 20; k++) begin
      @(posedge clk); #1;
      b_start = (k + 1 == mid_k);
      if (b_done) begin
        done_k = k;
        break;
      end
    end
    b_start = 1'b0;
  endtask

  task automatic test_reset;
    rstn = 1'b0; b_start = 1'b1; s_start = 1'b1; b_abort = 1'b0; s_abort = 1'b0; fault_and = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({b_bist_en, b_busy, b_done, b_pass} !== 4'b0) begin
      failures++; $display("FAIL reset_ctrl: bist_en/busy/done/pass=%b want 0000", {b_bist_en, b_busy, b_done, b_pass});
    end
    checks++;
    if (b_sel !== 4'd0 || b_a !== 32'h0 || b_b !== 32'h0) begin
      failures++; $display("FAIL reset_bus: sel=%0d a=%h b=%h want 0", b_sel, b_a, b_b);
    end
    checks++;
    if (b_sig !== 32'h0) begin
      failures++; $display("FAIL reset_sig: got %h want 0", b_sig);
    end
    checks++;
    if ({s_bist_en, s_busy, s_done, s_pass, s_sel} !== 8'b0 || s_sig !== 32'h0) begin
      failures++; $display("FAIL reset_small: ctrl=%b sel=%0d sig=%h want 0", {s_bist_en, s_busy, s_done, s_pass}, s_sel, s_sig);
    end
    b_start = 1'b0; s_start = 1'b0;
    rstn = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    checks++;
    if ({b_bist_en, b_busy, b_done} !== 3'b0 || {s_bist_en, s_busy, s_done} !== 3'b0) begin
      failures++; $display("FAIL idle_after_reset: big=%b small=%b want 000", {b_bist_en, b_busy, b_done}, {s_bist_en, s_busy, s_done});
    end
  endtask

  task automatic test_small_sequence;
    int          dk;
    logic [31:0] exp_sig;
    dk      = -1;
    exp_sig = model_signature(2, 1'b0);
    s_start = 1'b1;
    for (int k = 0; k < SMALL_LAT + 10; k++) begin
      @(posedge clk); #1;
      if (k == 0) s_start = 1'b0;
      if (k >= 1 && k <= 2 * NOPS) begin
        checks++;
        if (s_sel !== 4'((k - 1) / 2) || s_a !== 32'h0 || s_b !== 32'h0 || s_bist_en !== 1'b1) begin
          failures++; $display("FAIL small_round0 k=%0d: sel=%0d a=%h b=%h en=%b want sel=%0d a=0 b=0 en=1", k, s_sel, s_a, s_b, s_bist_en, (k - 1) / 2);
        end
      end
      if (k == 2 * NOPS + 2) begin
        checks++;
        if (s_sel !== 4'd0 || s_a !== 32'h8000_0000 || s_b !== 32'h1) begin
          failures++; $display("FAIL small_round1_ops: sel=%0d a=%h b=%h want 0 80000000 00000001", s_sel, s_a, s_b);
        end
      end
      if (s_done) begin
        dk = k;
        break;
      end
    end
    checks++;
    if (dk + 1 != SMALL_LAT) begin
      failures++; $display("FAIL small_latency: got %0d want %0d", dk + 1, SMALL_LAT);
    end
    checks++;
    if (s_sig !== exp_sig || s_busy !== 1'b0 || s_pass !== (exp_sig == 32'h0)) begin
      failures++; $display("FAIL small_result: sig=%h busy=%b pass=%b want sig=%h busy=0 pass=%b", s_sig, s_busy, s_pass, exp_sig, exp_sig == 32'h0);
    end
  endtask

  task automatic test_golden;
    int dk;
    big_run(-1, dk);
    checks++;
    if (dk + 1 != BIG_LAT) begin
      failures++; $display("FAIL golden_latency: got %0d want %0d", dk + 1, BIG_LAT);
    end
    checks++;
    if (b_sig !== SIG_GOLD || b_pass !== 1'b1) begin
      failures++; $display("FAIL golden_sig: sig=%h pass=%b want sig=%h pass=1", b_sig, b_pass, SIG_GOLD);
    end
    repeat ($urandom_range(2, 8)) @(posedge clk);
    #1;
    checks++;
    if (b_done !== 1'b1 || b_busy !== 1'b0 || b_bist_en !== 1'b0 || b_pass !== 1'b1 || b_sig !== SIG_GOLD) begin
      failures++; $display("FAIL done_hold: done=%b busy=%b en=%b pass=%b sig=%h want 1 0 0 1 %h", b_done, b_busy, b_bist_en, b_pass, b_sig, SIG_GOLD);
    end
  endtask

  task automatic test_fault_and;
    int          dk;
    logic [31:0] exp_sig;
    exp_sig   = model_signature(BIG_ROUNDS, 1'b1);
    fault_and = 1'b1;
    big_run(-1, dk);
    fault_and = 1'b0;
    checks++;
    if (dk < 0 || b_done !== 1'b1 || b_pass !== 1'b0) begin
      failures++; $display("FAIL fault_flags: done_k=%0d done=%b pass=%b want done=1 pass=0", dk, b_done, b_pass);
    end
    checks++;
    if (b_sig !== exp_sig || b_sig === SIG_GOLD) begin
      failures++; $display("FAIL fault_sig: sig=%h want %h (differs from %h)", b_sig, exp_sig, SIG_GOLD);
    end
  endtask

  task automatic test_mid_start;
    int dk;
    int mid;
    mid = $urandom_range(5, BIG_LAT - 10);
    big_run(mid, dk);
    checks++;
    if (dk + 1 != BIG_LAT || b_sig !== SIG_GOLD || b_pass !== 1'b1) begin
      failures++; $display("FAIL mid_start at %0d: lat=%0d sig=%h pass=%b want lat=%0d sig=%h pass=1", mid, dk + 1, b_sig, b_pass, BIG_LAT, SIG_GOLD);
    end
  endtask

  task automatic test_abort;
    int          dk;
    int          abort_k;
    logic [31:0] sig_before;
    abort_k    = 3 * ROUND_LEN + 1 + $urandom_range(0, ROUND_LEN - 1);
    sig_before = 32'h0;
    b_start    = 1'b1;
    for (int k = 0; k < abort_k; k++) begin
      @(posedge clk); #1;
      b_start = 1'b0;
      if (k == abort_k - 1) begin
        b_abort    = 1'b1;
        sig_before = b_sig;
      end
    end
    @(posedge clk); #1;
    b_abort = 1'b0;
    checks++;
    if ({b_bist_en, b_busy, b_done, b_pass} !== 4'b0) begin
      failures++; $display("FAIL abort_ctrl at %0d: en/busy/done/pass=%b want 0000", abort_k, {b_bist_en, b_busy, b_done, b_pass});
    end
    checks++;
    if (b_sig !== sig_before) begin
      failures++; $display("FAIL abort_sig_kept: got %h want %h", b_sig, sig_before);
    end
    b_start = 1'b1; b_abort = 1'b1;
    @(posedge clk); #1;
    b_start = 1'b0; b_abort = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (b_busy !== 1'b0 || b_bist_en !== 1'b0) begin
      failures++; $display("FAIL abort_start_idle: busy=%b en=%b want 0 0", b_busy, b_bist_en);
    end
    big_run(-1, dk);
    checks++;
    if (dk + 1 != BIG_LAT || b_sig !== SIG_GOLD || b_pass !== 1'b1) begin
      failures++; $display("FAIL rerun_after_abort: lat=%0d sig=%h pass=%b want %0d %h 1", dk + 1, b_sig, b_pass, BIG_LAT, SIG_GOLD);
    end
  endtask

  task automatic test_reset_mid_run;
    int dk;
    int rst_k;
    rst_k   = 5 * ROUND_LEN + 1 + 2 * $urandom_range(0, NOPS - 1);
    b_start = 1'b1;
    for (int k = 0; k <= rst_k; k++) begin
      @(posedge clk); #1;
      b_start = 1'b0;
    end
    checks++;
    if (b_busy !== 1'b1 || b_bist_en !== 1'b1) begin
      failures++; $display("FAIL pre_reset_busy: busy=%b en=%b want 1 1", b_busy, b_bist_en);
    end
    rstn = 1'b0;
    #1;
    checks++;
    if ({b_bist_en, b_busy, b_done, b_pass, b_sel} !== 8'b0 || b_a !== 32'h0 || b_b !== 32'h0 || b_sig !== 32'h0) begin
      failures++; $display("FAIL async_reset: ctrl=%b sel=%0d a=%h b=%h sig=%h want 0", {b_bist_en, b_busy, b_done, b_pass}, b_sel, b_a, b_b, b_sig);
    end
    #2;
    rstn = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({b_busy, b_done, b_pass} !== 3'b0) begin
      failures++; $display("FAIL post_reset_idle: busy/done/pass=%b want 000", {b_busy, b_done, b_pass});
    end
    big_run(-1, dk);
    checks++;
    if (dk + 1 != BIG_LAT || b_sig !== SIG_GOLD || b_pass !== 1'b1) begin
      failures++; $display("FAIL rerun_after_reset: lat=%0d sig=%h pass=%b want %0d %h 1", dk + 1, b_sig, b_pass, BIG_LAT, SIG_GOLD);
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    test_reset();
    test_small_sequence();
    test_golden();
    test_fault_and();
    test_mid_start();
    test_abort();
    test_reset_mid_run();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
